// File: rtl/pipelined_processor_core.sv
// pipelined_processor_core: 5-stage in-order 32-bit core with operand forwarding, EX-resolved branches and HLT.
// Register file and unified instruction/data memory are internal and preloaded hierarchically.
module pipelined_processor_core #(
    parameter int MEM_WORDS = 1024,
    parameter int XLEN = 32
) (
    input logic clk1,
    input logic rst
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [5:0] op_add = 6'd0, op_sub = 6'd1, op_and = 6'd2, op_or = 6'd3;
    localparam logic [5:0] op_slt = 6'd4, op_mul = 6'd5, op_lw = 6'd8, op_sw = 6'd9;
    localparam logic [5:0] op_addi = 6'd10, op_subi = 6'd11, op_slti = 6'd12;
    localparam logic [5:0] op_bneqz = 6'd13, op_beqz = 6'd14, op_hlt = 6'd63;

    logic [XLEN-1:0] reg_bank [0:31];
    logic [XLEN-1:0] mem [0:MEM_WORDS-1];
    logic [XLEN-1:0] PC;
    logic HALTED, TAKEN_BRANCH;
    logic halt_pending;

    logic if_id_v;
    logic [XLEN-1:0] if_id_ir, if_id_npc;

    logic id_ex_v, id_ex_we;
    logic [5:0] id_ex_op;
    logic [4:0] id_ex_rs, id_ex_rt, id_ex_dest;
    logic [XLEN-1:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;

    logic ex_mem_v, ex_mem_we;
    logic [5:0] ex_mem_op;
    logic [4:0] ex_mem_dest;
    logic [XLEN-1:0] ex_mem_alu, ex_mem_b;

    logic mem_wb_v, mem_wb_we, mem_wb_hlt;
    logic [4:0] mem_wb_dest;
    logic [XLEN-1:0] mem_wb_res;

    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, id_rd, id_dest;
    logic [XLEN-1:0] id_imm, rf_a, rf_b, a_f, b_f, alu;
    logic id_rr, id_rm, id_we, wb_wr, ex_fwd, taken, hlt_in_id, fetch_en;

    assign id_op = if_id_ir[31:26];
    assign id_rs = if_id_ir[25:21];
    assign id_rt = if_id_ir[20:16];
    assign id_rd = if_id_ir[15:11];
    assign id_imm = {{(XLEN-16){if_id_ir[15]}}, if_id_ir[15:0]};
    assign id_rr = id_op <= op_mul;
    assign id_rm = id_op == op_addi || id_op == op_subi || id_op == op_slti;
    assign id_dest = id_rr ? id_rd : id_rt;
    assign id_we = (id_rr || id_rm || id_op == op_lw) && id_dest != 5'd0;

    // WB result is visible to the same-cycle ID read (write-through)
    assign wb_wr = mem_wb_v && mem_wb_we;
    assign rf_a = id_rs == 5'd0 ? '0 : (wb_wr && mem_wb_dest == id_rs) ? mem_wb_res : reg_bank[id_rs];
    assign rf_b = id_rt == 5'd0 ? '0 : (wb_wr && mem_wb_dest == id_rt) ? mem_wb_res : reg_bank[id_rt];

    // Load data is not forwarded from EX/MEM: the instruction right after LW sees the stale value
    assign ex_fwd = ex_mem_v && ex_mem_we && ex_mem_op != op_lw;
    assign a_f = (ex_fwd && ex_mem_dest == id_ex_rs) ? ex_mem_alu :
                 (wb_wr && mem_wb_dest == id_ex_rs) ? mem_wb_res : id_ex_a;
    assign b_f = (ex_fwd && ex_mem_dest == id_ex_rt) ? ex_mem_alu :
                 (wb_wr && mem_wb_dest == id_ex_rt) ? mem_wb_res : id_ex_b;

    always_comb begin
        alu = '0;
        case (id_ex_op)
            op_add: alu = a_f + b_f;
            op_sub: alu = a_f - b_f;
            op_and: alu = a_f & b_f;
            op_or: alu = a_f | b_f;
            op_slt: alu = XLEN'($signed(a_f) < $signed(b_f));
            op_mul: alu = a_f * b_f;
            op_addi, op_lw, op_sw: alu = a_f + id_ex_imm;
            op_subi: alu = a_f - id_ex_imm;
            op_slti: alu = XLEN'($signed(a_f) < $signed(id_ex_imm));
            default: alu = '0;
        endcase
    end

    assign taken = id_ex_v && ((id_ex_op == op_bneqz && a_f != '0) || (id_ex_op == op_beqz && a_f == '0));
    assign hlt_in_id = if_id_v && id_op == op_hlt;
    assign fetch_en = !hlt_in_id && !halt_pending;

    always_ff @(posedge clk1) begin
        if (rst) begin
            PC <= '0;
            HALTED <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            halt_pending <= 1'b0;
            if_id_v <= 1'b0;
            id_ex_v <= 1'b0;
            ex_mem_v <= 1'b0;
            mem_wb_v <= 1'b0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= taken;
            PC <= taken ? id_ex_npc + id_ex_imm : fetch_en ? PC + XLEN'(1) : PC;
            if_id_v <= fetch_en && !taken;
            id_ex_v <= if_id_v && !taken;
            ex_mem_v <= id_ex_v;
            mem_wb_v <= ex_mem_v;
            halt_pending <= halt_pending || (hlt_in_id && !taken);
            HALTED <= mem_wb_v && mem_wb_hlt;
        end
    end

    always_ff @(posedge clk1) begin
        if (!HALTED) begin
            if_id_ir <= mem[PC[AW-1:0]];
            if_id_npc <= PC + XLEN'(1);
            id_ex_op <= id_op;
            id_ex_rs <= id_rs;
            id_ex_rt <= id_rt;
            id_ex_dest <= id_dest;
            id_ex_we <= id_we;
            id_ex_a <= rf_a;
            id_ex_b <= rf_b;
            id_ex_imm <= id_imm;
            id_ex_npc <= if_id_npc;
            ex_mem_op <= id_ex_op;
            ex_mem_dest <= id_ex_dest;
            ex_mem_we <= id_ex_we;
            ex_mem_alu <= alu;
            ex_mem_b <= b_f;
            mem_wb_hlt <= ex_mem_op == op_hlt;
            mem_wb_dest <= ex_mem_dest;
            mem_wb_we <= ex_mem_we;
            mem_wb_res <= ex_mem_op == op_lw ? mem[ex_mem_alu[AW-1:0]] : ex_mem_alu;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst && !HALTED && wb_wr)
            reg_bank[mem_wb_dest] <= mem_wb_res;
        if (!rst && !HALTED && ex_mem_v && ex_mem_op == op_sw)
            mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
    end
endmodule

// File: tb/tb_pipelined_processor_core.sv
// tb_pipelined_processor_core: directed programs with hand-computed register/memory results.
module tb_pipelined_processor_core;
    logic clk1 = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int pulses;
    logic [31:0] prog [$];

    pipelined_processor_core dut (.clk1(clk1), .rst(rst));

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic load(input string tag);
        rst = 1'b1;
        @(negedge clk1);
        for (int i = 0; i < 1024; i++) dut.mem[i] = 32'd0;
        for (int k = 0; k < 32; k++) dut.reg_bank[k] = 32'(k);
        foreach (prog[i]) dut.mem[i] = prog[i];
        @(negedge clk1);
        check({tag, "_rst_pc"}, dut.PC, 32'd0);
        check({tag, "_rst_halted"}, 32'(dut.HALTED), 32'd0);
        check({tag, "_rst_taken"}, 32'(dut.TAKEN_BRANCH), 32'd0);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int max, output int p);
        int n;
        n = 0;
        p = 0;
        while (dut.HALTED !== 1'b1 && n < max) begin
            @(negedge clk1);
            n++;
            if (dut.TAKEN_BRANCH === 1'b1) p++;
        end
        check({tag, "_halted"}, 32'(dut.HALTED), 32'd1);
    endtask

    initial begin
        // load / add / store
        prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                 32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        load("lds");
        dut.mem[120] = 32'd85;
        run_to_halt("lds", 100, pulses);
        check("lds_mem121", dut.mem[121], 32'd130);
        check("lds_r1", dut.reg_bank[1], 32'd120);
        check("lds_r2", dut.reg_bank[2], 32'd130);

        // back-to-back forwarding and register write-through
        prog = '{ri(6'd10, 5'd1, 5'd0, 16'd10), ri(6'd10, 5'd2, 5'd1, 16'd20),
                 rr(6'd0, 5'd3, 5'd2, 5'd1), rr(6'd1, 5'd4, 5'd3, 5'd1),
                 rr(6'd2, 5'd5, 5'd3, 5'd2), rr(6'd3, 5'd6, 5'd3, 5'd2), 32'hfc000000};
        load("fwd");
        run_to_halt("fwd", 100, pulses);
        check("fwd_r1", dut.reg_bank[1], 32'd10);
        check("fwd_r2", dut.reg_bank[2], 32'd30);
        check("fwd_r3", dut.reg_bank[3], 32'd40);
        check("fwd_sub", dut.reg_bank[4], 32'd30);
        check("fwd_and", dut.reg_bank[5], 32'd8);
        check("fwd_or", dut.reg_bank[6], 32'd62);

        // branch loop: 5! with HLT directly behind the branch
        prog = '{ri(6'd10, 5'd1, 5'd0, 16'd5), ri(6'd10, 5'd2, 5'd0, 16'd1),
                 rr(6'd5, 5'd2, 5'd2, 5'd1), ri(6'd11, 5'd1, 5'd1, 16'd1),
                 ri(6'd13, 5'd0, 5'd1, 16'hfffd), 32'hfc000000,
                 ri(6'd10, 5'd6, 5'd0, 16'd99)};
        load("loop");
        run_to_halt("loop", 200, pulses);
        check("loop_r2", dut.reg_bank[2], 32'd120);
        check("loop_r1", dut.reg_bank[1], 32'd0);
        check("loop_pulses", 32'(pulses), 32'd4);
        check("loop_r6", dut.reg_bank[6], 32'd6);

        // halt freeze
        prog = '{ri(6'd10, 5'd1, 5'd0, 16'd3), 32'hfc000000,
                 ri(6'd10, 5'd5, 5'd0, 16'd7), ri(6'd9, 5'd1, 5'd0, 16'd50)};
        load("hlt");
        run_to_halt("hlt", 100, pulses);
        check("hlt_pc", dut.PC, 32'd2);
        repeat (20) @(negedge clk1);
        check("hlt_pc_stable", dut.PC, 32'd2);
        check("hlt_r5", dut.reg_bank[5], 32'd5);
        check("hlt_r1", dut.reg_bank[1], 32'd3);
        check("hlt_mem50", dut.mem[50], 32'd0);
        check("hlt_still", 32'(dut.HALTED), 32'd1);

        // reset mid-run: MUL in WB at the reset edge must not write
        prog = '{ri(6'd10, 5'd1, 5'd0, 16'd5), ri(6'd10, 5'd2, 5'd0, 16'd1),
                 rr(6'd5, 5'd2, 5'd2, 5'd1), ri(6'd11, 5'd1, 5'd1, 16'd1),
                 ri(6'd13, 5'd0, 5'd1, 16'hfffd), 32'hfc000000};
        load("mid");
        repeat (5) @(negedge clk1);
        check("mid_r1_t4", dut.reg_bank[1], 32'd5);
        check("mid_r2_t4", dut.reg_bank[2], 32'd2);
        @(negedge clk1);
        check("mid_r2_t5", dut.reg_bank[2], 32'd1);
        rst = 1'b1;
        @(negedge clk1);
        check("mid_r2_abort", dut.reg_bank[2], 32'd1);
        check("mid_pc", dut.PC, 32'd0);
        check("mid_halted", 32'(dut.HALTED), 32'd0);
        rst = 1'b0;
        run_to_halt("mid", 200, pulses);
        check("mid_r2", dut.reg_bank[2], 32'd120);
        check("mid_r1", dut.reg_bank[1], 32'd0);
        check("mid_pulses", 32'(pulses), 32'd4);

        // SLT/SLTI, R0 writes, undefined opcode, BEQZ squash
        prog = '{ri(6'd11, 5'd1, 5'd0, 16'd1), ri(6'd12, 5'd4, 5'd1, 16'd0),
                 rr(6'd4, 5'd5, 5'd1, 5'd0), rr(6'd4, 5'd6, 5'd0, 5'd1),
                 ri(6'd10, 5'd0, 5'd0, 16'd9), rr(6'd0, 5'd7, 5'd0, 5'd0),
                 ri(6'd16, 5'd8, 5'd0, 16'h4005), ri(6'd14, 5'd0, 5'd0, 16'd1),
                 ri(6'd10, 5'd9, 5'd0, 16'd1), 32'hfc000000};
        load("slt");
        run_to_halt("slt", 100, pulses);
        check("slt_r1", dut.reg_bank[1], 32'hffffffff);
        check("slt_slti", dut.reg_bank[4], 32'd1);
        check("slt_neg", dut.reg_bank[5], 32'd1);
        check("slt_pos", dut.reg_bank[6], 32'd0);
        check("slt_r0", dut.reg_bank[0], 32'd0);
        check("slt_r0fwd", dut.reg_bank[7], 32'd0);
        check("slt_undef", dut.reg_bank[8], 32'd8);
        check("slt_beqz_sq", dut.reg_bank[9], 32'd9);
        check("slt_pulses", 32'(pulses), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipelined_processor_core.md
Name: pipelined_processor_core

Overview:
- 32-bit, 5-stage in-order pipelined processor: IF, ID, EX, MEM, WB.
- Uses a 32x32 register file and a unified 1024-word instruction/data memory.
- Both arrays are internal and preloaded hierarchically by benches.
- No external bus. Execution runs from PC until a HLT instruction retires.

Parameters:
- MEM_WORDS, 1024, depth of the unified word-addressed memory; address = low 10 bits of the computed value.
- XLEN, 32, datapath width.

Ports:
- clk1  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Hierarchically visible state:
  - reg_bank[0:31] (32-bit registers).
  - mem[0:1023] (32-bit words).
  - PC (32-bit).
  - HALTED (1-bit).
  - TAKEN_BRANCH (1-bit).
- Reset:
  - Sets PC=0, HALTED=0, TAKEN_BRANCH=0.
  - Clears all pipeline latches to bubbles (no writes).
  - reg_bank and mem are NOT cleared.
  - Reset mid-run aborts all in-flight instructions; none of them write.
- Instruction format: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]. imm is sign-extended to 32 bits.
- RR ALU ops (result to rd = rs op rt):
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed compare; result 1 or 0.
  - MUL 000101: low 32 bits of the product.
- RM ALU ops (result to rt = rs op imm): ADDI 001010, SUBI 001011, SLTI 001100 (signed).
- Load/store:
  - LW 001000: rt <= mem[rs+imm].
  - SW 001001: mem[rs+imm] <= rt.
- Branches: BNEQZ 001101 (taken if rs!=0), BEQZ 001110 (taken if rs==0). Target = PC_of_branch+1+imm (word units).
- HLT 111111.
- Undefined opcodes execute as NOP.
- Arithmetic wraps modulo 2^32; there are no exceptions.
- R0 reads as 0 and writes to R0 are discarded.
- Throughput and timing:
  - One instruction per cycle.
  - Instruction fetched in cycle t writes its register in WB at the end of cycle t+4.
  - Memory reads are combinational. Memory writes are synchronous in MEM.
- Data hazards:
  - Forwarding into EX operands from the EX/MEM latch (ALU results).
  - Forwarding into EX operands from the MEM/WB latch (ALU or load data).
  - Register-file write-through: an ID read of a register being written by WB in the same cycle returns the new value.
  - EX/MEM forwarding has priority over MEM/WB forwarding.
  - No load-use interlock: an instruction immediately following LW that uses its rt receives the stale value. Software inserts one independent instruction.
- Branches:
  - Resolved in EX.
  - If taken: PC <= target on the next edge, and the two younger instructions in IF/ID and ID/EX are squashed to bubbles.
  - TAKEN_BRANCH=1 for that one cycle, else 0.
  - Not-taken branches cost no cycles.
- HLT:
  - When HLT is in ID, fetch stops and PC freezes; bubbles are inserted behind it.
  - Older instructions complete normally.
  - When HLT reaches WB, HALTED <= 1.
  - While HALTED=1: no fetch, no register or memory writes, state is stable until rst.
- Simultaneous events:
  - A taken branch in EX and HLT in ID: the branch wins, HLT is squashed and fetch resumes at the target.
  - SW and a fetch from the same address in one cycle: the fetch returns the old word.

Test Plan:
- Load/add/store:
  - Setup: reg_bank[k]=k, mem[120]=85.
  - Program: 28010078 ADDI R1,R0,120; 0c631800; 20220000 LW R2,0(R1); 0c631800; 2842002d ADDI R2,R2,45; 0c631800; 24220001 SW R2,1(R1); fc000000 HLT.
  - Expected: after 100 cycles, mem[121]=130, R1=120, R2=130, HALTED=1.
- Back-to-back forwarding:
  - Program: ADDI R1,R0,10; ADDI R2,R1,20; ADD R3,R2,R1; HLT.
  - Expected: R1=10, R2=30, R3=40.
- Branch loop:
  - Program: R1=5, R2=1; loop MUL R2,R2,R1; SUBI R1,R1,1; BNEQZ R1,loop; HLT.
  - Expected: R2=120, R1=0.
  - Expected: TAKEN_BRANCH pulses 4 times.
  - Expected: squashed instructions never write.
- Halt freeze:
  - Program: instructions after HLT (e.g. ADDI R5,R0,7).
  - Expected: R5 unchanged, PC stable, no mem writes after HALTED=1.
- Reset mid-run:
  - Stimulus: assert rst for one cycle during the loop program.
  - Expected: PC=0, HALTED=0, no writes during reset; the program re-executes from address 0.
- SLT/SLTI:
  - Program: R1=-1 via SUBI R1,R0,1; SLTI R4,R1,0.
  - Expected: R4=1 (signed compare). Writes to R0 leave R0=0.
